// File: rtl/fir_pkg.sv
// -----------------------------------------------------------------------------
// fir_pkg
// Types, constants and helpers shared by the transmit fir_interpolator and the
// receive fir.
//   sample_t               : signed 8-bit Q1.7 sample
//   coeff_t                : signed 8-bit Q1.7 coefficient
//   INTERP_DEFAULT_COEFFS  : 6-tap prototype, h[n] lives in bits [8n+7:8n]
//   interp_state_t         : interpolator control states
//   saturate8()            : clamp a wide signed value to [-128, 127]
// -----------------------------------------------------------------------------
package fir_pkg;

   localparam int DATA_W = 8;
   localparam int COEF_W = 8;

   typedef logic signed [DATA_W-1:0] sample_t;
   typedef logic signed [COEF_W-1:0] coeff_t;

   // h[0..5] = {-16, 40, 104, 104, 40, -16}; h[0] in the low byte.
   localparam logic [6*COEF_W-1:0] INTERP_DEFAULT_COEFFS = {
      8'hF0,   // h[5] = -16
      8'h28,   // h[4] =  40
      8'h68,   // h[3] = 104
      8'h68,   // h[2] = 104
      8'h28,   // h[1] =  40
      8'hF0    // h[0] = -16
   };

   typedef enum logic {
      S_IDLE = 1'b0,
      S_EMIT = 1'b1
   } interp_state_t;

   function automatic sample_t saturate8(input logic signed [31:0] v);
      if (v > 32'sd127) begin
         return 8'sh7F;
      end
      if (v < -32'sd128) begin
         return 8'sh80;
      end
      return sample_t'(v[7:0]);
   endfunction

endpackage

// File: rtl/fir_interpolator_phase_mac.sv
// -----------------------------------------------------------------------------
// fir_interpolator_phase_mac
// Combinational multiply-accumulate for one polyphase branch: sums
// COEFFS[k*L + phase] * taps[k] over the K delay-line taps, scales by 2^-7
// (arithmetic shift, floor) and saturates to 8 bits.
// Build option: define FIR_INTERPOLATOR_ROUND_EN to add half an LSB (64)
// before the shift, turning the floor into round-half-up.
//   taps_i   : delay line, taps_i[0] is the newest sample
//   phase_i  : polyphase branch to evaluate, 0..L-1
//   sample_o : saturated Q1.7 result
// -----------------------------------------------------------------------------
module fir_interpolator_phase_mac
   import fir_pkg::*;
#(
   parameter int INTERP_FACTOR  = 2,
   parameter int TAPS_PER_PHASE = 3,
   parameter int PH_W           = 1,
   parameter logic [INTERP_FACTOR*TAPS_PER_PHASE*COEF_W-1:0] COEFFS = INTERP_DEFAULT_COEFFS
) (
   input  sample_t           taps_i [TAPS_PER_PHASE],
   input  logic [PH_W-1:0]   phase_i,
   output sample_t           sample_o
);

   localparam int ACC_W = DATA_W + COEF_W + $clog2(TAPS_PER_PHASE);

   localparam logic signed [ACC_W-1:0] HALF_LSB = ACC_W'(64);

   logic signed [ACC_W-1:0]         acc;
   logic signed [ACC_W-1:0]         scaled;
   logic signed [DATA_W+COEF_W-1:0] prod;
   coeff_t                          coef;
   int                              idx;

   function automatic logic signed [ACC_W-1:0] round_shift(input logic signed [ACC_W-1:0] a);
`ifdef FIR_INTERPOLATOR_ROUND_EN
      return (a + HALF_LSB) >>> 7;
`else
      return a >>> 7;
`endif
   endfunction

   always_comb begin
      acc  = '0;
      prod = '0;
      coef = '0;
      idx  = 0;
      for (int k = 0; k < TAPS_PER_PHASE; k++) begin
         // Branch p uses every L-th prototype tap starting at p.
         idx  = k * INTERP_FACTOR + int'(phase_i);
         coef = coeff_t'(COEFFS[idx*COEF_W +: COEF_W]);
         prod = coef * taps_i[k];
         acc  = acc + ACC_W'(prod);
      end
      scaled   = round_shift(acc);
      sample_o = saturate8(32'(scaled));
   end

endmodule

// File: rtl/fir_interpolator.sv
// -----------------------------------------------------------------------------
// fir_interpolator
// Polyphase L-times interpolating FIR for the transmit path. Each accepted
// input sample yields INTERP_FACTOR output samples, one per polyphase branch,
// through a valid/ready stream with a registered output.
// Build option: FIR_INTERPOLATOR_ROUND_EN (see fir_interpolator_phase_mac).
//   clk       : clock, all logic on rising edge
//   rst       : synchronous active-high reset; clears output and delay line
//   in        : signed input sample
//   in_valid  : input sample present
//   in_ready  : block can accept input this cycle (combinational)
//   out       : signed output sample, registered
//   out_valid : out holds a sample not yet consumed
//   out_ready : downstream accepts out
// -----------------------------------------------------------------------------
module fir_interpolator
   import fir_pkg::*;
#(
   parameter int INTERP_FACTOR  = 2,
   parameter int TAPS_PER_PHASE = 3,
   parameter logic [INTERP_FACTOR*TAPS_PER_PHASE*COEF_W-1:0] COEFFS = INTERP_DEFAULT_COEFFS
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic signed [DATA_W-1:0] in,
   input  logic                     in_valid,
   output logic                     in_ready,
   output logic signed [DATA_W-1:0] out,
   output logic                     out_valid,
   input  logic                     out_ready
);

   localparam int PH_W = (INTERP_FACTOR > 1) ? $clog2(INTERP_FACTOR) : 1;
   localparam logic [PH_W-1:0] LAST_PH = PH_W'(INTERP_FACTOR - 1);

   interp_state_t   state_q, state_d;
   logic [PH_W-1:0] phase_q, phase_d;
   sample_t         taps_q [TAPS_PER_PHASE];
   sample_t         taps_d [TAPS_PER_PHASE];
   sample_t         out_q, out_d;
   sample_t         mac_out;
   logic            accept;
   logic            load;

   // A new sample is taken only once the last branch of the current one is
   // leaving this cycle, which gives back-to-back output with no bubble.
   assign in_ready  = !rst && ((state_q == S_IDLE) || ((phase_q == LAST_PH) && out_ready));
   assign accept    = in_valid && in_ready;
   assign out       = out_q;
   assign out_valid = (state_q == S_EMIT);

   always_comb begin
      taps_d = taps_q;
      if (accept) begin
         taps_d[0] = in;
         for (int k = 1; k < TAPS_PER_PHASE; k++) begin
            taps_d[k] = taps_q[k-1];
         end
      end
   end

   always_comb begin
      state_d = state_q;
      phase_d = phase_q;
      load    = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (accept) begin
               state_d = S_EMIT;
               phase_d = '0;
               load    = 1'b1;
            end
         end
         S_EMIT: begin
            if (out_ready) begin
               if (phase_q != LAST_PH) begin
                  phase_d = phase_q + PH_W'(1);
                  load    = 1'b1;
               end else if (accept) begin
                  phase_d = '0;
                  load    = 1'b1;
               end else begin
                  state_d = S_IDLE;
                  phase_d = '0;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
            phase_d = '0;
         end
      endcase
   end

   // The MAC sees next-state delay line and phase so the result lands in the
   // output register on the same edge that advances the control.
   fir_interpolator_phase_mac #(
      .INTERP_FACTOR  (INTERP_FACTOR),
      .TAPS_PER_PHASE (TAPS_PER_PHASE),
      .PH_W           (PH_W),
      .COEFFS         (COEFFS)
   ) u_phase_mac (
      .taps_i   (taps_d),
      .phase_i  (phase_d),
      .sample_o (mac_out)
   );

   assign out_d = load ? mac_out : out_q;

   // Output / state register boundary
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         phase_q <= '0;
         out_q   <= '0;
         for (int k = 0; k < TAPS_PER_PHASE; k++) begin
            taps_q[k] <= '0;
         end
      end else begin
         state_q <= state_d;
         phase_q <= phase_d;
         out_q   <= out_d;
         taps_q  <= taps_d;
      end
   end

endmodule

// File: tb/tb_fir_interpolator.sv
// -----------------------------------------------------------------------------
// tb_fir_interpolator
// Directed self-checking bench for fir_interpolator in its default
// configuration (L=2, K=3, floor truncation).
// -----------------------------------------------------------------------------
module tb_fir_interpolator;

   logic              clk;
   logic              rst;
   logic signed [7:0] din;
   logic              din_vld;
   logic              ir;
   logic signed [7:0] dout;
   logic              ov;
   logic              ordy;

   int n_pass  = 0;
   int n_total = 0;

   int xs_q[$];
   int ys_q[$];

   fir_interpolator dut (
      .clk       (clk),
      .rst       (rst),
      .in        (din),
      .in_valid  (din_vld),
      .in_ready  (ir),
      .out       (dout),
      .out_valid (ov),
      .out_ready (ordy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst     = 1'b1;
      din_vld = 1'b0;
      tick();
      rst = 1'b0;
   endtask

   // Feeds xs_q back-to-back whenever the block is ready and checks one
   // output per cycle against ys_q; ofs gives the in_ready parity at start.
   task automatic run(input string tag, input int ofs);
      int j;
      j = 0;
      for (int c = 0; c < ys_q.size(); c++) begin
         if (j < xs_q.size()) begin
            din     = 8'(xs_q[j]);
            din_vld = 1'b1;
         end else begin
            din     = 8'h5A;
            din_vld = 1'b0;
         end
         #1;
         chk({tag, "_in_ready"}, ir, (((c + ofs) % 2) == 0) ? 1 : 0);
         if (ir === 1'b1 && din_vld) j++;
         tick();
         chk($sformatf("%s_out[%0d]", tag, c), dout, ys_q[c]);
         chk({tag, "_out_valid"}, ov, 1);
      end
      din_vld = 1'b0;
      tick();
      chk({tag, "_idle_valid"}, ov, 0);
      chk({tag, "_idle_hold"}, dout, ys_q[ys_q.size()-1]);
   endtask

   initial begin
      // Reset hold with garbage input offered
      rst     = 1'b1;
      din     = 8'hAA;
      din_vld = 1'b1;
      ordy    = 1'b1;
      for (int i = 0; i < 20; i++) begin
         #1;
         chk("rst_in_ready", ir, 0);
         tick();
         chk("rst_out", dout, 0);
         chk("rst_out_valid", ov, 0);
      end
      rst     = 1'b0;
      din_vld = 1'b0;
      #1;
      chk("first_in_ready", ir, 1);

      // Impulse
      xs_q = {127, 0, 0, 0};
      ys_q = {-16, 39, 103, 103, 39, -16, 0, 0};
      run("impulse", 0);

      // DC gain +127 from a cleared delay line
      do_reset();
      xs_q.delete();
      ys_q = {-16, 39, 87, 127};
      for (int i = 0; i < 20; i++) xs_q.push_back(127);
      for (int i = 0; i < 36; i++) ys_q.push_back(127);
      run("dc_pos", 0);

      // DC gain -128
      do_reset();
      xs_q.delete();
      ys_q = {16, -40, -88, -128};
      for (int i = 0; i < 20; i++) xs_q.push_back(-128);
      for (int i = 0; i < 36; i++) ys_q.push_back(-128);
      run("dc_neg", 0);

      // Positive saturation then an in-range phase
      do_reset();
      xs_q = {127, 127, -128};
      ys_q = {-16, 39, 87, 127, 127, 47};
      run("sat_pos", 0);

      // Negative saturation
      do_reset();
      xs_q = {-128, -128, 127};
      ys_q = {16, -40, -88, -128, -128, -49};
      run("sat_neg", 0);

      // Backpressure on the first output, garbage input during the stall
      do_reset();
      ordy    = 1'b1;
      din     = 8'sd127;
      din_vld = 1'b1;
      #1;
      chk("bp_in_ready0", ir, 1);
      tick();
      chk("bp_first_out", dout, -16);
      ordy = 1'b0;
      for (int c = 0; c < 5; c++) begin
         din_vld = c[0];
         din     = 8'(8'h33 + c);
         #1;
         chk("bp_stall_in_ready", ir, 0);
         tick();
         chk("bp_stall_out", dout, -16);
         chk("bp_stall_valid", ov, 1);
      end
      ordy = 1'b1;
      xs_q = {0, 0, 0};
      ys_q = {39, 103, 103, 39, -16, 0, 0};
      run("bp_resume", 1);

      // Reset while phase 1 of an impulse is on the output
      do_reset();
      din     = 8'sd127;
      din_vld = 1'b1;
      tick();
      chk("mrst_p0", dout, -16);
      din_vld = 1'b0;
      tick();
      chk("mrst_p1", dout, 39);
      rst = 1'b1;
      #1;
      chk("mrst_in_ready", ir, 0);
      tick();
      chk("mrst_out", dout, 0);
      chk("mrst_valid", ov, 0);
      rst  = 1'b0;
      xs_q = {127, 0, 0, 0};
      ys_q = {-16, 39, 103, 103, 39, -16, 0, 0};
      run("mrst_impulse", 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
